// File: rtl/mem_pkg.sv
// Shared types for the unified memory port arbiter: FSM state, port owner and the
// latched request payload.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_starve_sel.sv
// Grant select between fetch and data requesters. Data wins unless fetch has
// already been passed over STARVE_MAX times in a row.
module arb_starve_sel
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_valid,
    input  logic       dm_valid,
    input  logic       grant_taken,
    output owner_t     winner,
    output logic [3:0] starve_cnt
);

    localparam logic [3:0] CntMax = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        winner = OWN_NONE;
        if (dm_valid && !(if_valid && cnt_q == CntMax)) begin
            winner = OWN_DM;
        end else if (if_valid) begin
            winner = OWN_IF;
        end
    end

    // Count only grants that pass over a waiting fetch; anything else restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_taken) begin
            if (winner == OWN_DM && if_valid) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and the memory stage, one
// transaction at a time, with data priority bounded by a starvation counter.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,

    input  logic                dm_req_valid,
    input  logic                dm_req_we,
    input  logic [DATA_W/8-1:0] dm_req_be,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic [DATA_W-1:0]   dm_req_wdata,
    output logic                dm_req_ready,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rsp_rdata,

    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [DATA_W/8-1:0] mem_req_be,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,

    output logic                busy,
    output logic                err_spurious
);

    arb_state_t state_q;
    owner_t     owner_q;
    mem_req_t   req_q, req_d;
    logic       err_q;

    owner_t     winner;
    logic [3:0] starve_cnt;
    logic       grant_taken;
    logic       rsp_hit;

    // Gated by rst_n so nothing leaks out combinationally while reset is held.
    assign grant_taken = rst_n && (state_q == IDLE) && (if_req_valid || dm_req_valid);

    arb_starve_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_req_valid),
        .dm_valid    (dm_req_valid),
        .grant_taken (grant_taken),
        .winner      (winner),
        .starve_cnt  (starve_cnt)
    );

    always_comb begin
        req_d = req_q;
        if (winner == OWN_DM) begin
            req_d.we    = dm_req_we;
            req_d.be    = dm_req_be;
            req_d.addr  = dm_req_addr;
            req_d.wdata = dm_req_wdata;
        end else begin
            req_d.we    = 1'b0;
            req_d.be    = '1;
            req_d.addr  = if_req_addr;
            req_d.wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // A response in the acceptance cycle is also spurious: memory latency is >= 1.
            if (mem_rsp_valid && state_q != WAIT_RSP) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (grant_taken) begin
                        owner_q <= winner;
                        req_q   <= req_d;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        owner_q <= OWN_NONE;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_req_ready = grant_taken && (winner == OWN_IF);
    assign dm_req_ready = grant_taken && (winner == OWN_DM);

    assign rsp_hit      = rst_n && (state_q == WAIT_RSP) && mem_rsp_valid;
    assign if_rsp_valid = rsp_hit && (owner_q == OWN_IF);
    assign dm_rsp_valid = rsp_hit && (owner_q == OWN_DM);
    assign if_rsp_data  = if_rsp_valid ? mem_rsp_rdata : '0;
    assign dm_rsp_rdata = dm_rsp_valid ? mem_rsp_rdata : '0;

    assign mem_req_valid = rst_n && (state_q == REQ);
    assign mem_req_we    = req_q.we;
    assign mem_req_be    = req_q.be;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wdata = req_q.wdata;

    assign busy         = rst_n && (state_q != IDLE);
    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and per-requester
// response scoreboards.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
    logic [3:0]  dm_req_be;
    logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_rdata;
    logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic        busy, err_spurious;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_we     (dm_req_we),
        .dm_req_be     (dm_req_be),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_ready  (dm_req_ready),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_rdata  (dm_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_be    (mem_req_be),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .busy          (busy),
        .err_spurious  (err_spurious)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: ready after ready_delay cycles in REQ, response one cycle later.
    logic [31:0] mem_arr [logic [31:0]];
    int unsigned ready_delay = 0;
    bit          model_rsp_en = 1'b1;
    int unsigned wait_cnt = 0;
    bit          rsp_due = 1'b0;
    logic [31:0] due_data = '0;
    logic        model_rsp_v = 1'b0;
    logic [31:0] model_rsp_d = '0;
    logic        man_rsp_v;
    logic [31:0] man_rsp_d;

    assign mem_rsp_valid = model_rsp_v | man_rsp_v;
    assign mem_rsp_rdata = model_rsp_v ? model_rsp_d : man_rsp_d;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h02A3_0293;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_word(a);
    endfunction

    initial mem_req_ready = 1'b0;

    always @(negedge clk) begin
        logic [31:0] w;
        model_rsp_v = 1'b0;
        model_rsp_d = '0;
        if (!rst_n) begin
            wait_cnt      = 0;
            rsp_due       = 1'b0;
            mem_req_ready = 1'b0;
        end else begin
            if (rsp_due && model_rsp_en) begin
                model_rsp_v = 1'b1;
                model_rsp_d = due_data;
            end
            rsp_due       = 1'b0;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (wait_cnt >= ready_delay) begin
                    mem_req_ready = 1'b1;
                    wait_cnt      = 0;
                    rsp_due       = 1'b1;
                    if (mem_req_we) begin
                        w = read_word(mem_req_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_req_be[b]) w[8*b +: 8] = mem_req_wdata[8*b +: 8];
                        mem_arr[mem_req_addr] = w;
                        due_data = '0;
                    end else begin
                        due_data = read_word(mem_req_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Scoreboard: expected response data per requester, popped on each response.
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];

    always @(negedge clk) begin
        #1;
        chk("rsp_exclusive", 32'(if_rsp_valid & dm_rsp_valid), 32'd0);
        if (if_rsp_valid) begin
            if (if_q.size() == 0) chk("if_rsp_unexpected", 32'(if_rsp_valid), 32'd0);
            else chk("if_rsp_data", if_rsp_data, if_q.pop_front());
        end else begin
            chk("if_rsp_data_zero", if_rsp_data, 32'd0);
        end
        if (dm_rsp_valid) begin
            if (dm_q.size() == 0) chk("dm_rsp_unexpected", 32'(dm_rsp_valid), 32'd0);
            else chk("dm_rsp_rdata", dm_rsp_rdata, dm_q.pop_front());
        end else begin
            chk("dm_rsp_rdata_zero", dm_rsp_rdata, 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic gi, output logic gd, output int waited);
        waited = 0;
        #1;
        while (!(if_req_ready || dm_req_ready) && waited < 16) begin
            cyc();
            waited++;
        end
        gi = if_req_ready;
        gd = dm_req_ready;
        chk("grant_seen", 32'(if_req_ready | dm_req_ready), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            cyc();
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic chk_quiet(input string t, input logic exp_err);
        chk({t, "_if_ready"}, 32'(if_req_ready), 32'd0);
        chk({t, "_dm_ready"}, 32'(dm_req_ready), 32'd0);
        chk({t, "_if_rsp"}, 32'(if_rsp_valid), 32'd0);
        chk({t, "_dm_rsp"}, 32'(dm_rsp_valid), 32'd0);
        chk({t, "_mem_valid"}, 32'(mem_req_valid), 32'd0);
        chk({t, "_mem_we"}, 32'(mem_req_we), 32'd0);
        chk({t, "_mem_be"}, 32'(mem_req_be), 32'd0);
        chk({t, "_mem_addr"}, mem_req_addr, 32'd0);
        chk({t, "_mem_wdata"}, mem_req_wdata, 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_err"}, 32'(err_spurious), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic gi, gd;
        int   w;
        int   dm_issued;
        logic [31:0] a;

        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_be = '0;
        dm_req_addr = '0; dm_req_wdata = '0;
        man_rsp_v = 1'b0; man_rsp_d = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        #1;
        chk_quiet("reset", 1'b0);

        // IF-only fetch with zero-wait memory.
        cyc();
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        if_q.push_back(32'h02A3_0293);
        #1;
        chk("t1_if_ready", 32'(if_req_ready), 32'd1);
        chk("t1_dm_ready", 32'(dm_req_ready), 32'd0);
        cyc();
        if_req_valid = 1'b0; if_req_addr = '0;
        #1;
        chk("t1_mem_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_mem_addr", mem_req_addr, 32'h10);
        chk("t1_mem_we", 32'(mem_req_we), 32'd0);
        chk("t1_mem_be", 32'(mem_req_be), 32'hF);
        chk("t1_if_ready_pulse", 32'(if_req_ready), 32'd0);
        cyc();
        chk("t1_wait_mem_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk); #2;
        chk("t1_if_rsp_n2", 32'(if_rsp_valid), 32'd1);
        chk("t1_dm_rsp_quiet", 32'(dm_rsp_valid), 32'd0);
        cyc();
        chk("t1_idle_n3", 32'(busy), 32'd0);

        // Simultaneous requests: DM first, IF on the next IDLE cycle (three cycles later).
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_be = 4'hF; dm_req_addr = 32'h1000;
        dm_q.push_back(read_word(32'h1000));
        if_q.push_back(read_word(32'h20));
        wait_grant(gi, gd, w);
        chk("t2_dm_first", 32'(gd), 32'd1);
        cyc();
        dm_req_valid = 1'b0;
        wait_grant(gi, gd, w);
        chk("t2_if_second", 32'(gi), 32'd1);
        chk("t2_if_gap", 32'(w), 32'd2);
        cyc();
        if_req_valid = 1'b0;
        wait_idle();

        // Starvation: IF held while DM requests back to back.
        cyc();
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        if_q.push_back(read_word(32'h40));
        dm_req_valid = 1'b1; dm_req_addr = 32'h2000;
        dm_q.push_back(read_word(32'h2000));
        dm_issued = 1;
        for (int d = 0; d < 6; d++) begin
            wait_grant(gi, gd, w);
            if (d == 4) chk("t3_cnt_at_max", 32'(dut.starve_cnt), 32'd4);
            chk($sformatf("t3_grant_dm_%0d", d), 32'(gd), 32'(d != 4));
            chk($sformatf("t3_grant_if_%0d", d), 32'(gi), 32'(d == 4));
            cyc();
            if (gi) begin
                if_req_valid = 1'b0;
                chk("t3_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
            end
            if (gd) begin
                if (dm_issued < 5) begin
                    a = 32'h2000 + 32'(4 * dm_issued);
                    dm_req_addr = a;
                    dm_q.push_back(read_word(a));
                    dm_issued++;
                end else begin
                    dm_req_valid = 1'b0;
                end
            end
        end
        wait_idle();

        // Store with a slow memory: payload held through REQ, then read it back.
        ready_delay = 3;
        cyc();
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_be = 4'h3;
        dm_req_addr = 32'h200; dm_req_wdata = 32'hDEAD_BEEF;
        dm_q.push_back(32'd0);
        wait_grant(gi, gd, w);
        chk("t4_dm_grant", 32'(gd), 32'd1);
        cyc();
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_be = '0;
        dm_req_addr = 32'hFFFF_FFFC; dm_req_wdata = '0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_valid_%0d", i), 32'(mem_req_valid), 32'd1);
            chk($sformatf("t4_addr_%0d", i), mem_req_addr, 32'h200);
            chk($sformatf("t4_wdata_%0d", i), mem_req_wdata, 32'hDEAD_BEEF);
            chk($sformatf("t4_be_%0d", i), 32'(mem_req_be), 32'h3);
            chk($sformatf("t4_we_%0d", i), 32'(mem_req_we), 32'd1);
            cyc();
        end
        chk("t4_accepted", 32'(mem_req_valid), 32'd0);
        wait_idle();
        ready_delay = 0;
        cyc();
        dm_req_valid = 1'b1; dm_req_be = 4'hF; dm_req_addr = 32'h200;
        dm_q.push_back((init_word(32'h200) & 32'hFFFF_0000) | 32'h0000_BEEF);
        wait_grant(gi, gd, w);
        cyc();
        dm_req_valid = 1'b0;
        wait_idle();
        chk("t4_err_clear", 32'(err_spurious), 32'd0);

        // Spurious response in IDLE: flagged, not routed, sticky.
        cyc();
        man_rsp_v = 1'b1; man_rsp_d = 32'hBAD0_BAD0;
        #1;
        chk("t5_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("t5_dm_rsp", 32'(dm_rsp_valid), 32'd0);
        cyc();
        man_rsp_v = 1'b0;
        #1;
        chk("t5_err_set", 32'(err_spurious), 32'd1);
        if_req_valid = 1'b1; if_req_addr = 32'h80;
        if_q.push_back(read_word(32'h80));
        wait_grant(gi, gd, w);
        cyc();
        if_req_valid = 1'b0;
        wait_idle();
        chk("t5_err_sticky", 32'(err_spurious), 32'd1);

        // Reset while waiting for a response; the late response must be dropped.
        model_rsp_en = 1'b0;
        cyc();
        if_req_valid = 1'b1; if_req_addr = 32'h30;
        wait_grant(gi, gd, w);
        cyc();
        if_req_valid = 1'b0;
        cyc();
        chk("t6_in_wait_busy", 32'(busy), 32'd1);
        chk("t6_in_wait_valid", 32'(mem_req_valid), 32'd0);
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        model_rsp_en = 1'b1;
        #1;
        chk_quiet("t6_after_reset", 1'b0);
        cyc();
        cyc();
        man_rsp_v = 1'b1; man_rsp_d = 32'h1234_5678;
        #1;
        chk("t6_late_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("t6_late_dm_rsp", 32'(dm_rsp_valid), 32'd0);
        cyc();
        man_rsp_v = 1'b0;
        #1;
        chk_quiet("t6_final", 1'b1);

        repeat (2) cyc();
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
